fusion_mac_pipe: RTL and testbench
==================================

# fusion_mac_pipe

Parametrised, pipelined successor to the fixed-width fusion multiplier. It takes CH independent channels of packed activations and weights at a run-time precision of 8, 4 or 2 bits. Each cycle it forms a per-channel dot product over the packed elements and accumulates it across a multi-beat burst into a saturating ACC_W-bit partial sum. The final sum is presented to the downstream adder tree / PE column over a valid/ready handshake, with optional psum seeding for chaining.

## Interface
- CH, 4: number of independent channels.
- IN_W, 8: bits per channel of packed activation and of packed weight; multiple of 8.
- ACC_W, 32: signed accumulator and output width per channel; ≥ 2*IN_W+2.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_prec  in  2  element precision: 00=8b, 01=4b, 10=2b, 11 treated as 8b.
- cfg_s_in  in  1  activation elements are signed (two's complement).
- cfg_s_wgt  in  1  weight elements are signed.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_last  in  1  final beat of burst.
- in_act  in  CH*IN_W  channel c at [c*IN_W +: IN_W].
- in_wgt  in  CH*IN_W  same packing as in_act.
- psum_in  in  CH*ACC_W  signed accumulator seed, sampled on first beat of burst.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_psum  out  CH*ACC_W  signed result per channel.
- out_sat  out  CH  per channel, sticky: saturation occurred during the burst.

## Operation
- Element width b = 8/4/2 per cfg_prec. N = IN_W/b elements per channel. Element k is bits [k*b +: b]; element 0 is the LSBs.
- Element value: sign-extended if the matching s flag is 1, else zero-extended.
- dot_c = Σ_k act_k*wgt_k, computed exactly in 2*IN_W+2 signed bits.
- Burst = one or more accepted beats ending with in_last=1. A single beat with in_last=1 is a complete burst.
- First beat of a burst (first accepted beat after reset or after a last beat):
  - latches cfg_prec, cfg_s_in, cfg_s_wgt and psum_in;
  - cfg changes on later beats are ignored until the next burst.
- Stage S1 registers dot_c, last and first flags, and s1_valid.
- Stage S2:
  - acc_c = (first ? seed_c : acc_c) + dot_c, saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1];
  - sat_c is set on clamp and cleared on first beat (before OR-in).
- On a last beat, S2 writes acc into out_psum/out_sat and sets out_valid.
- Output register: single entry, holds stable while out_valid && !out_ready.
- Stall conditions:
  - s2_block = s1_valid && s1_last && out_valid && !out_ready;
  - in_ready = !s2_block.
  - While blocked, S1 holds; non-last S1 beats never block.
- Simultaneous output consume and new last beat in S2 on the same edge: the new result is loaded and out_valid stays 1. No bubble, no loss.

## Timing
- Reset (asynchronous assert): S1/S2 valids, acc, out_psum, out_sat, out_valid = 0. in_ready = 1.
- Reset mid-burst: partial accumulation is discarded. The next accepted beat is a first beat.
- Latency: beat accepted at edge T → S1 at T, accumulated at T+1. For a last beat, out_valid=1 from T+1.
- Throughput: one beat per cycle per channel when unblocked.
- out_valid deasserts on the consume edge unless a new result loads on that same edge.
- Back-to-back single-beat bursts with out_ready=1 produce one result per cycle.

## Test plan
- 8b, s_in=s_wgt=1, CH0 act=0x80, wgt=0x80, seed 0, in_last=1 → out_psum[0]=16384, out_sat[0]=0, out_valid one cycle after accept edge.
- 2b unsigned, act=0x1B, wgt=0xE4 on all channels, single beat → every out_psum=4 (3*0+2*1+1*2+0*3).
- 4b signed, act=0xF3, wgt=0x27, 3 beats, seed 100 → 100+3*(3*7+(-1)*2)=157. cfg_prec toggled to 00 on beat 2 → result unchanged.
- ACC_W=18 instance, 8b unsigned, act=wgt=0xFF, 3 beats:
  - 3*65025 clamps to 131071, out_sat=1;
  - following burst 1*1 → 1, out_sat=0.
- Backpressure: out_ready=0, two back-to-back single-beat bursts (results 6 then 12):
  - first result held stable, in_ready falls while second sits in S1;
  - one out_ready pulse → 12 appears next cycle, nothing lost or duplicated.
- Reset: rst_n=0 after 2 beats of a 4-beat burst → all outputs 0 immediately. After release, new single-beat burst with seed 5, dot 2 → 7.

Source files
------------

// File: rtl/fusion_mac_pipe.sv
// rtl/fusion_mac_pipe.sv - multi-precision packed dot-product MAC with burst accumulation
module fusion_mac_pipe #(
    parameter int CH    = 4,
    parameter int IN_W  = 8,
    parameter int ACC_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          cfg_prec,
    input  logic                cfg_s_in,
    input  logic                cfg_s_wgt,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [CH*IN_W-1:0]  in_act,
    input  logic [CH*IN_W-1:0]  in_wgt,
    input  logic [CH*ACC_W-1:0] psum_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*ACC_W-1:0] out_psum,
    output logic [CH-1:0]       out_sat
);
    localparam int DOT_W = 2*IN_W + 2;

    // Elements are widened to DOT_W so each product and the running sum stay exact.
    function automatic logic [DOT_W-1:0] dot_fn(input logic [IN_W-1:0] a, input logic [IN_W-1:0] w,
                                                input logic [1:0] prec, input logic sa, input logic sw);
        logic [DOT_W-1:0] acc, ea, ew;
        acc = '0;
        case (prec)
            2'b01: for (int k = 0; k < IN_W/4; k++) begin
                ea  = {{(DOT_W-4){sa & a[k*4+3]}}, a[k*4 +: 4]};
                ew  = {{(DOT_W-4){sw & w[k*4+3]}}, w[k*4 +: 4]};
                acc = acc + ea * ew;
            end
            2'b10: for (int k = 0; k < IN_W/2; k++) begin
                ea  = {{(DOT_W-2){sa & a[k*2+1]}}, a[k*2 +: 2]};
                ew  = {{(DOT_W-2){sw & w[k*2+1]}}, w[k*2 +: 2]};
                acc = acc + ea * ew;
            end
            default: for (int k = 0; k < IN_W/8; k++) begin
                ea  = {{(DOT_W-8){sa & a[k*8+7]}}, a[k*8 +: 8]};
                ew  = {{(DOT_W-8){sw & w[k*8+7]}}, w[k*8 +: 8]};
                acc = acc + ea * ew;
            end
        endcase
        return acc;
    endfunction

    // Returns {clamped, value}; overflow shows as disagreement of the top two sum bits.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] base, input logic [DOT_W-1:0] dot);
        logic [ACC_W:0] sum;
        sum = {base[ACC_W-1], base} + {{(ACC_W+1-DOT_W){dot[DOT_W-1]}}, dot};
        if (sum[ACC_W] != sum[ACC_W-1])
            return {1'b1, sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}};
        return {1'b0, sum[ACC_W-1:0]};
    endfunction

    logic             first_q, s1_valid_q, s1_last_q, s1_first_q, out_valid_q;
    logic [1:0]       prec_q;
    logic             s_in_q, s_wgt_q;
    logic [DOT_W-1:0] s1_dot_q   [CH];
    logic [ACC_W-1:0] s1_seed_q  [CH];
    logic [ACC_W-1:0] acc_q      [CH];
    logic [ACC_W-1:0] out_psum_q [CH];
    logic [CH-1:0]    sat_q, out_sat_q;

    logic [1:0]       prec_eff;
    logic             s_in_eff, s_wgt_eff, s2_block, accept, s2_fire;
    logic [DOT_W-1:0] dot_d [CH];
    logic [ACC_W-1:0] acc_d [CH];
    logic [CH-1:0]    sat_d;

    // Burst configuration comes straight from the ports on the first beat, then from the latch.
    assign prec_eff  = first_q ? cfg_prec  : prec_q;
    assign s_in_eff  = first_q ? cfg_s_in  : s_in_q;
    assign s_wgt_eff = first_q ? cfg_s_wgt : s_wgt_q;

    assign s2_block  = s1_valid_q && s1_last_q && out_valid_q && !out_ready;
    assign in_ready  = !s2_block;
    assign accept    = in_valid && in_ready;
    assign s2_fire   = s1_valid_q && !s2_block;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        sat_d    = '0;
        out_psum = '0;
        for (int c = 0; c < CH; c++) begin
            logic [ACC_W:0] r;
            dot_d[c] = dot_fn(in_act[c*IN_W +: IN_W], in_wgt[c*IN_W +: IN_W], prec_eff, s_in_eff, s_wgt_eff);
            r        = sat_add(s1_first_q ? s1_seed_q[c] : acc_q[c], s1_dot_q[c]);
            acc_d[c] = r[ACC_W-1:0];
            sat_d[c] = (!s1_first_q && sat_q[c]) || r[ACC_W];
            out_psum[c*ACC_W +: ACC_W] = out_psum_q[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q     <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_first_q  <= 1'b0;
            out_valid_q <= 1'b0;
            prec_q      <= 2'b00;
            s_in_q      <= 1'b0;
            s_wgt_q     <= 1'b0;
            sat_q       <= '0;
            out_sat_q   <= '0;
            for (int c = 0; c < CH; c++) begin
                s1_dot_q[c]   <= '0;
                s1_seed_q[c]  <= '0;
                acc_q[c]      <= '0;
                out_psum_q[c] <= '0;
            end
        end else begin
            if (accept) first_q <= in_last;
            if (accept && first_q) begin
                prec_q  <= cfg_prec;
                s_in_q  <= cfg_s_in;
                s_wgt_q <= cfg_s_wgt;
            end
            if (!s2_block) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_last_q  <= in_last;
                    s1_first_q <= first_q;
                    for (int c = 0; c < CH; c++) begin
                        s1_dot_q[c]  <= dot_d[c];
                        s1_seed_q[c] <= psum_in[c*ACC_W +: ACC_W];
                    end
                end
            end
            if (s2_fire) begin
                sat_q <= sat_d;
                for (int c = 0; c < CH; c++) acc_q[c] <= acc_d[c];
            end
            // A new result overrides a same-edge consume so out_valid never bubbles.
            if (s2_fire && s1_last_q) begin
                out_valid_q <= 1'b1;
                out_sat_q   <= sat_d;
                for (int c = 0; c < CH; c++) out_psum_q[c] <= acc_d[c];
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fusion_mac_pipe.sv
// tb/tb_fusion_mac_pipe.sv - table-driven scoreboard bench for fusion_mac_pipe
module tb_fusion_mac_pipe;
    localparam int CH = 4, IN_W = 8, ACC_W = 32, A18 = 18;

    logic                 clk = 1'b0, rst_n = 1'b0;
    logic [1:0]           cfg_prec = 2'b00;
    logic                 cfg_s_in = 1'b0, cfg_s_wgt = 1'b0;
    logic                 in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic                 in_ready, in_ready18, out_valid, out_valid18;
    logic [CH*IN_W-1:0]   in_act = '0, in_wgt = '0;
    logic [CH*ACC_W-1:0]  psum_in = '0, out_psum;
    logic [CH*A18-1:0]    psum_in18 = '0, out_psum18;
    logic [CH-1:0]        out_sat, out_sat18;

    always #5 clk = ~clk;

    fusion_mac_pipe #(.CH(CH), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_prec(cfg_prec), .cfg_s_in(cfg_s_in), .cfg_s_wgt(cfg_s_wgt),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_act(in_act), .in_wgt(in_wgt),
        .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .out_sat(out_sat));

    fusion_mac_pipe #(.CH(CH), .IN_W(IN_W), .ACC_W(A18)) dut18 (
        .clk(clk), .rst_n(rst_n), .cfg_prec(cfg_prec), .cfg_s_in(cfg_s_in), .cfg_s_wgt(cfg_s_wgt),
        .in_valid(in_valid), .in_ready(in_ready18), .in_last(in_last), .in_act(in_act), .in_wgt(in_wgt),
        .psum_in(psum_in18), .out_valid(out_valid18), .out_ready(out_ready), .out_psum(out_psum18), .out_sat(out_sat18));

    typedef struct {
        logic [CH-1:0][31:0] psum;
        logic [CH-1:0]       sat;
    } exp_t;

    typedef struct {
        logic [1:0]  prec, prec_l;
        logic        s_in, s_wgt;
        logic [7:0]  act, wgt, act_l, wgt_l;
        logic [31:0] seed;
        int          beats;
        logic [31:0] exp;
        logic        exp_sat;
    } vec_t;

    exp_t exp_q[$], exp18_q[$], mon_e, mon_e18;
    int   n_cmp = 0, n_fail = 0;
    logic chk18 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic exp_t mk(input logic [31:0] v, input logic s);
        exp_t e;
        for (int c = 0; c < CH; c++) begin
            e.psum[c] = v;
            e.sat[c]  = s;
        end
        return e;
    endfunction

    task automatic beat(input logic [1:0] p, input logic si, input logic sw, input logic [CH*IN_W-1:0] a,
                        input logic [CH*IN_W-1:0] w, input logic [31:0] seed, input logic last);
        int t = 0;
        cfg_prec = p; cfg_s_in = si; cfg_s_wgt = sw;
        in_act = a; in_wgt = w; psum_in = {CH{seed}}; in_last = last; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                fail("in_ready_timeout");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) fail("unexpected_result");
            else begin
                mon_e = exp_q.pop_front();
                for (int c = 0; c < CH; c++)
                    chk($sformatf("psum_ch%0d", c), 64'(out_psum[c*ACC_W +: ACC_W]), 64'(mon_e.psum[c]));
                chk("sat", 64'(out_sat), 64'(mon_e.sat));
            end
        end
        if (chk18 && rst_n && out_valid18 && out_ready) begin
            if (exp18_q.size() == 0) fail("unexpected_result18");
            else begin
                mon_e18 = exp18_q.pop_front();
                for (int c = 0; c < CH; c++)
                    chk($sformatf("psum18_ch%0d", c), 64'(out_psum18[c*A18 +: A18]), 64'(mon_e18.psum[c][A18-1:0]));
                chk("sat18", 64'(out_sat18), 64'(mon_e18.sat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        exp_t e1;
        tbl[0] = '{2'b10, 2'b10, 1'b0, 1'b0, 8'h1B, 8'hE4, 8'h1B, 8'hE4, 32'd0,       1, 32'd4,          1'b0};
        tbl[1] = '{2'b01, 2'b00, 1'b1, 1'b1, 8'hF3, 8'h27, 8'hF3, 8'h27, 32'd100,     3, 32'd157,        1'b0};
        tbl[2] = '{2'b00, 2'b00, 1'b1, 1'b1, 8'h80, 8'h7F, 8'h80, 8'h7F, 32'd0,       1, 32'(-16256),    1'b0};
        tbl[3] = '{2'b01, 2'b10, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'd0,       2, 32'(-60),       1'b0};
        tbl[4] = '{2'b00, 2'b00, 1'b1, 1'b1, 8'h01, 8'h01, 8'h01, 8'h01, 32'h7FFFFFFF, 1, 32'h7FFFFFFF,  1'b1};
        tbl[5] = '{2'b00, 2'b00, 1'b1, 1'b1, 8'h80, 8'h01, 8'h80, 8'h01, 32'h80000000, 1, 32'h80000000,  1'b1};
        tbl[6] = '{2'b00, 2'b01, 1'b1, 1'b1, 8'h7F, 8'h7F, 8'h80, 8'h7F, 32'h7FFFFFF0, 2, 32'd2147467391, 1'b1};
        tbl[7] = '{2'b11, 2'b11, 1'b0, 1'b0, 8'h0F, 8'h10, 8'h0F, 8'h10, 32'(-5),     1, 32'd235,        1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_psum", 64'(out_psum[63:0]), 64'd0);
        chk("reset_out_sat", 64'(out_sat), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 8-bit signed -128*-128 on channel 0 only, with latency check
        e1 = mk(32'd0, 1'b0);
        e1.psum[0] = 32'd16384;
        exp_q.push_back(e1);
        beat(2'b00, 1'b1, 1'b1, {{(CH-1)*IN_W{1'b0}}, 8'h80}, {CH{8'h80}}, 32'd0, 1'b1);
        chk("latency_not_yet", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("latency_valid", 64'(out_valid), 64'd1);
        drain();

        // table bursts; later beats carry altered cfg flags and a junk seed which must be ignored
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(tbl[i].exp, tbl[i].exp_sat));
            for (int b = 0; b < tbl[i].beats; b++) begin
                if (b == 0)
                    beat(tbl[i].prec, tbl[i].s_in, tbl[i].s_wgt, {CH{tbl[i].act}}, {CH{tbl[i].wgt}},
                         tbl[i].seed, tbl[i].beats == 1);
                else
                    beat(tbl[i].prec_l, ~tbl[i].s_in, ~tbl[i].s_wgt, {CH{tbl[i].act_l}}, {CH{tbl[i].wgt_l}},
                         32'hDEAD0000, b == tbl[i].beats - 1);
            end
        end
        drain();

        // 18-bit accumulator clamps while the 32-bit one does not; sticky flag clears next burst
        chk18 = 1'b1;
        exp18_q.push_back(mk(32'd131071, 1'b1));
        exp18_q.push_back(mk(32'd1, 1'b0));
        exp_q.push_back(mk(32'd195075, 1'b0));
        exp_q.push_back(mk(32'd1, 1'b0));
        for (int b = 0; b < 3; b++)
            beat(2'b00, 1'b0, 1'b0, {CH{8'hFF}}, {CH{8'hFF}}, 32'd0, b == 2);
        beat(2'b00, 1'b0, 1'b0, {CH{8'h01}}, {CH{8'h01}}, 32'd0, 1'b1);
        drain();
        if (exp18_q.size() != 0) fail("drain18");
        chk18 = 1'b0;
        chk("in_ready18_match", 64'(in_ready18), 64'(in_ready));

        // backpressure: two single-beat bursts while the output is not consumed
        out_ready = 1'b0;
        exp_q.push_back(mk(32'd6, 1'b0));
        exp_q.push_back(mk(32'd12, 1'b0));
        beat(2'b00, 1'b0, 1'b0, {CH{8'h02}}, {CH{8'h03}}, 32'd0, 1'b1);
        beat(2'b00, 1'b0, 1'b0, {CH{8'h03}}, {CH{8'h04}}, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_psum", 64'(out_psum[31:0]), 64'd6);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_psum", 64'(out_psum[31:0]), 64'd12);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("bp_second_held", 64'(out_psum[127:96]), 64'd12);
        out_ready = 1'b1;
        drain();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // reset in the middle of a burst with a held result
        out_ready = 1'b0;
        beat(2'b00, 1'b0, 1'b0, {CH{8'h01}}, {CH{8'h03}}, 32'd0, 1'b1);
        beat(2'b00, 1'b0, 1'b0, {CH{8'h01}}, {CH{8'h01}}, 32'd9, 1'b0);
        beat(2'b00, 1'b0, 1'b0, {CH{8'h01}}, {CH{8'h01}}, 32'd9, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_psum", 64'(out_psum[63:0]), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(mk(32'd7, 1'b0));
        beat(2'b00, 1'b0, 1'b0, {CH{8'h01}}, {CH{8'h02}}, 32'd5, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
